// File: rtl/pipeline_control_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_control_pkg;

  localparam int REG_AW = 5;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HZD_STALL = 2'd1,
    DMEM_WAIT = 2'd2
  } pipeCtrlState_e;

  typedef enum logic {
    PC_PLUS4 = 1'b0,
    PC_JUMP  = 1'b1
  } pcSel_e;

endpackage

// File: rtl/pipeline_control_if.sv
// Hazard/handshake inputs and stage-control outputs of the pipeline sequencer.
// PIPE_CTRL_PERF_EN adds the stall_cycles / flush_count counter signals.
interface pipeline_control_if;
  import pipeline_control_pkg::*;

  logic [REG_AW-1:0] rs1_addr_id;
  logic [REG_AW-1:0] rs2_addr_id;
  logic [REG_AW-1:0] rd_addr_ex;
  logic              uses_rs1_id;
  logic              uses_rs2_id;
  logic              jump_id;
  logic              branch_taken;
  logic              rd_wr_en_ex;
  logic              data_rd_en_ex;
  logic              imem_ready;
  logic              dmem_req_mem;
  logic              dmem_ready;

  logic              en_if;
  logic              en_id;
  logic              en_ex;
  logic              en_mem;
  logic              en_wb;
  logic              bubble_ex;
  logic              flush_id;
  pcSel_e            pc_sel;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]       stall_cycles;
  logic [31:0]       flush_count;

  modport master (
    input  rs1_addr_id, rs2_addr_id, rd_addr_ex, uses_rs1_id, uses_rs2_id,
           jump_id, branch_taken, rd_wr_en_ex, data_rd_en_ex, imem_ready,
           dmem_req_mem, dmem_ready,
    output en_if, en_id, en_ex, en_mem, en_wb, bubble_ex, flush_id, pc_sel,
           stall_cycles, flush_count
  );

  modport slave (
    output rs1_addr_id, rs2_addr_id, rd_addr_ex, uses_rs1_id, uses_rs2_id,
           jump_id, branch_taken, rd_wr_en_ex, data_rd_en_ex, imem_ready,
           dmem_req_mem, dmem_ready,
    input  en_if, en_id, en_ex, en_mem, en_wb, bubble_ex, flush_id, pc_sel,
           stall_cycles, flush_count
  );
`else
  modport master (
    input  rs1_addr_id, rs2_addr_id, rd_addr_ex, uses_rs1_id, uses_rs2_id,
           jump_id, branch_taken, rd_wr_en_ex, data_rd_en_ex, imem_ready,
           dmem_req_mem, dmem_ready,
    output en_if, en_id, en_ex, en_mem, en_wb, bubble_ex, flush_id, pc_sel
  );

  modport slave (
    output rs1_addr_id, rs2_addr_id, rd_addr_ex, uses_rs1_id, uses_rs2_id,
           jump_id, branch_taken, rd_wr_en_ex, data_rd_en_ex, imem_ready,
           dmem_req_mem, dmem_ready,
    input  en_if, en_id, en_ex, en_mem, en_wb, bubble_ex, flush_id, pc_sel
  );
`endif

endinterface

// File: rtl/pipeline_control_hazard_detect.sv
// Combinational ID/EX operand-hazard detector; returns the stall length 0..2.
module pipeline_control_hazard_detect
  import pipeline_control_pkg::*;
(
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              uses_rs1_i,
  input  logic              uses_rs2_i,
  input  logic              jump_i,
  input  logic              rd_wr_en_i,
  input  logic              load_i,
  output logic [1:0]        stall_len_o
);

  logic hit;

  assign hit = (rd_addr_i != '0) &&
               ((uses_rs1_i && (rs1_addr_i == rd_addr_i)) ||
                (uses_rs2_i && (rs2_addr_i == rd_addr_i)));

  // Jumps resolve in ID, so a load feeding one needs an extra cycle over an ALU result.
  always_comb begin
    stall_len_o = 2'd0;
    if (hit && jump_i && rd_wr_en_i) begin
      stall_len_o = load_i ? 2'd2 : 2'd1;
    end else if (hit && load_i) begin
      stall_len_o = 2'd1;
    end
  end

endmodule

// File: rtl/pipeline_control.sv
// Stall/flush sequencer for the five-stage pipeline: stage enables, bubbles, PC select.
// Optional PIPE_CTRL_PERF_EN adds stall-cycle and jump-flush counters.
//
// state     | meaning
// RUN       | normal flow; hazards, jumps and fetch waits evaluated here
// HZD_STALL | remaining hazard stall cycles counted down in stall_cnt_q
// DMEM_WAIT | whole pipe frozen on data memory; saved_q holds the state to resume
module pipeline_control
  import pipeline_control_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  pipeline_control_if.master ctrl
);

  pipeCtrlState_e state_q, state_d;
  pipeCtrlState_e saved_q, saved_d;
  pipeCtrlState_e eff_state;
  logic [1:0]     stall_cnt_q, stall_cnt_d;
  logic [1:0]     stall_len;

  logic en_if, en_id, en_ex, en_mem, en_wb, bubble_ex, flush_id;
  pcSel_e pc_sel;

  pipeline_control_hazard_detect u_hazard_detect (
    .rs1_addr_i  (ctrl.rs1_addr_id),
    .rs2_addr_i  (ctrl.rs2_addr_id),
    .rd_addr_i   (ctrl.rd_addr_ex),
    .uses_rs1_i  (ctrl.uses_rs1_id),
    .uses_rs2_i  (ctrl.uses_rs2_id),
    .jump_i      (ctrl.jump_id),
    .rd_wr_en_i  (ctrl.rd_wr_en_ex),
    .load_i      (ctrl.data_rd_en_ex),
    .stall_len_o (stall_len)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      saved_q     <= RUN;
      stall_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // The cycle the memory completes already behaves as the resumed state.
  assign eff_state = (state_q == DMEM_WAIT) ? saved_q : state_q;

  always_comb begin
    state_d     = state_q;
    saved_d     = saved_q;
    stall_cnt_d = stall_cnt_q;
    en_if       = 1'b1;
    en_id       = 1'b1;
    en_ex       = 1'b1;
    en_mem      = 1'b1;
    en_wb       = 1'b1;
    bubble_ex   = 1'b0;
    flush_id    = 1'b0;
    pc_sel      = PC_PLUS4;

    if (ctrl.dmem_req_mem && !ctrl.dmem_ready) begin
      en_if   = 1'b0;
      en_id   = 1'b0;
      en_ex   = 1'b0;
      en_mem  = 1'b0;
      en_wb   = 1'b0;
      state_d = DMEM_WAIT;
      if (state_q != DMEM_WAIT) saved_d = state_q;
    end else if (eff_state == HZD_STALL) begin
      en_if       = 1'b0;
      en_id       = 1'b0;
      bubble_ex   = 1'b1;
      stall_cnt_d = (stall_cnt_q == 2'd0) ? 2'd0 : stall_cnt_q - 2'd1;
      state_d     = (stall_cnt_q <= 2'd1) ? RUN : HZD_STALL;
    end else if (stall_len != 2'd0) begin
      // This cycle is the first stall cycle; the counter holds the ones still owed.
      en_if       = 1'b0;
      en_id       = 1'b0;
      bubble_ex   = 1'b1;
      stall_cnt_d = stall_len - 2'd1;
      state_d     = (stall_len == 2'd1) ? RUN : HZD_STALL;
    end else if (ctrl.branch_taken) begin
      pc_sel   = PC_JUMP;
      flush_id = 1'b1;
      state_d  = RUN;
    end else begin
      if (!ctrl.imem_ready) begin
        en_if    = 1'b0;
        flush_id = 1'b1;
      end
      state_d = RUN;
    end
  end

  assign ctrl.en_if     = en_if;
  assign ctrl.en_id     = en_id;
  assign ctrl.en_ex     = en_ex;
  assign ctrl.en_mem    = en_mem;
  assign ctrl.en_wb     = en_wb;
  assign ctrl.bubble_ex = bubble_ex;
  assign ctrl.flush_id  = flush_id;
  assign ctrl.pc_sel    = pc_sel;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      if (!en_id) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush_id && (pc_sel == PC_JUMP)) flush_count_q <= flush_count_q + 32'd1;
    end
  end

  assign ctrl.stall_cycles = stall_cycles_q;
  assign ctrl.flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Randomized bench for pipeline_control against a cycle-level reference model.
module tb_pipeline_control;
  import pipeline_control_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pipeline_control_if ifc ();

  pipeline_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (ifc)
  );

  int checks = 0;
  int errors = 0;

  // reference model: outstanding stall cycles after the current one, perf tallies
  int          m_pend = 0;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;

  localparam logic [7:0] EXP_NORMAL = 8'b1111_1000;
  localparam logic [7:0] EXP_STALL  = 8'b0011_1100;
  localparam logic [7:0] EXP_JUMP   = 8'b1111_1011;
  localparam logic [7:0] EXP_IWAIT  = 8'b0111_1010;
  localparam logic [7:0] EXP_FREEZE = 8'b0000_0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] obs();
    return {ifc.en_if, ifc.en_id, ifc.en_ex, ifc.en_mem, ifc.en_wb,
            ifc.bubble_ex, ifc.flush_id, (ifc.pc_sel == PC_JUMP)};
  endfunction

  task automatic set_idle();
    ifc.rs1_addr_id   = 5'd0;
    ifc.rs2_addr_id   = 5'd0;
    ifc.rd_addr_ex    = 5'd0;
    ifc.uses_rs1_id   = 1'b0;
    ifc.uses_rs2_id   = 1'b0;
    ifc.jump_id       = 1'b0;
    ifc.branch_taken  = 1'b0;
    ifc.rd_wr_en_ex   = 1'b0;
    ifc.data_rd_en_ex = 1'b0;
    ifc.imem_ready    = 1'b1;
    ifc.dmem_req_mem  = 1'b0;
    ifc.dmem_ready    = 1'b0;
  endtask

  // Drive one cycle at the falling edge, predict, compare, then let the rising edge pass.
  task automatic drive(input string tag, input int rs1, input int rs2, input int u1,
                       input int u2, input int jmp, input int tkn, input int rd,
                       input int wr, input int ld, input int im, input int rq,
                       input int rdy);
    logic [7:0] exp;
    bit         hit;
    int         len;
    @(negedge clk);
    ifc.rs1_addr_id   = 5'(rs1);
    ifc.rs2_addr_id   = 5'(rs2);
    ifc.uses_rs1_id   = u1[0];
    ifc.uses_rs2_id   = u2[0];
    ifc.jump_id       = jmp[0];
    ifc.branch_taken  = tkn[0];
    ifc.rd_addr_ex    = 5'(rd);
    ifc.rd_wr_en_ex   = wr[0];
    ifc.data_rd_en_ex = ld[0];
    ifc.imem_ready    = im[0];
    ifc.dmem_req_mem  = rq[0];
    ifc.dmem_ready    = rdy[0];
    #2;
`ifdef PIPE_CTRL_PERF_EN
    check({tag, ".stall_cycles"}, ifc.stall_cycles, m_stall);
    check({tag, ".flush_count"}, ifc.flush_count, m_flush);
`endif
    hit = (rd != 0) && ((u1[0] && rs1 == rd) || (u2[0] && rs2 == rd));
    if (rq[0] && !rdy[0]) begin
      exp = EXP_FREEZE;
    end else if (m_pend > 0) begin
      exp = EXP_STALL;
      m_pend--;
    end else begin
      len = 0;
      if (hit && jmp[0] && wr[0]) len = ld[0] ? 2 : 1;
      else if (hit && ld[0])      len = 1;
      if (len > 0) begin
        exp = EXP_STALL;
        m_pend = len - 1;
      end else if (tkn[0]) begin
        exp = EXP_JUMP;
        m_flush++;
      end else if (!im[0]) begin
        exp = EXP_IWAIT;
      end else begin
        exp = EXP_NORMAL;
      end
    end
    if (!exp[6]) m_stall++;
    check(tag, 32'(obs()), 32'(exp));
    @(posedge clk);
  endtask

  task automatic idle_cycle(input string tag);
    drive(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    set_idle();
    #3;
    check("reset.outputs", 32'(obs()), 32'(EXP_NORMAL));
`ifdef PIPE_CTRL_PERF_EN
    check("reset.stall_cycles", ifc.stall_cycles, 32'd0);
    check("reset.flush_count", ifc.flush_count, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    idle_cycle("idle0");

    // LW x5 in EX, ADD x6,x5,x1 in ID: one bubble, then flow resumes
    drive("loaduse.stall", 5, 1, 1, 1, 0, 0, 5, 1, 1, 1, 0, 0);
    drive("loaduse.after", 5, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    idle_cycle("loaduse.idle");

    // LW x5 in EX, taken BEQ x5,x0 in ID: two stall cycles, then the jump
    drive("ldjump.s1", 5, 0, 1, 1, 1, 1, 5, 1, 1, 1, 0, 0);
    drive("ldjump.s2", 5, 0, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0);
    drive("ldjump.jump", 5, 0, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0);
    idle_cycle("ldjump.idle");

    // ALU result feeding a jump: one stall cycle
    drive("alujump.s1", 7, 0, 1, 0, 1, 0, 7, 1, 0, 1, 0, 0);
    drive("alujump.go", 7, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0);

    // x0 destination never stalls
    drive("x0.nostall", 0, 0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0);

    // taken JAL coincident with fetch wait
    drive("jal.imemwait", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    drive("imemwait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // dmem ready in the same cycle as the request: no wait
    drive("dmem.nowait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);

    // dmem wait of 3 cycles during HZD_STALL with one stall cycle still owed
    drive("dwait.s1", 5, 0, 1, 1, 1, 1, 5, 1, 1, 1, 0, 0);
    drive("dwait.w1", 5, 0, 1, 1, 1, 1, 0, 0, 0, 1, 1, 0);
    drive("dwait.w2", 5, 0, 1, 1, 1, 1, 0, 0, 0, 1, 1, 0);
    drive("dwait.w3", 5, 0, 1, 1, 1, 1, 0, 0, 0, 1, 1, 0);
    drive("dwait.resume", 5, 0, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1);
    drive("dwait.jump", 5, 0, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0);

    // reset pulsed mid-wait while a stall is still owed
    drive("rstwait.s1", 5, 0, 1, 1, 1, 1, 5, 1, 1, 1, 0, 0);
    drive("rstwait.w1", 5, 0, 1, 1, 1, 1, 0, 0, 0, 1, 1, 0);
    @(negedge clk);
    set_idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("rstwait.outputs", 32'(obs()), 32'(EXP_NORMAL));
`ifdef PIPE_CTRL_PERF_EN
    check("rstwait.stall_cycles", ifc.stall_cycles, 32'd0);
    check("rstwait.flush_count", ifc.flush_count, 32'd0);
`endif
    m_pend  = 0;
    m_stall = 0;
    m_flush = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle("rstwait.after");

    for (int i = 0; i < 3000; i++) begin
      drive("rand",
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 4) != 0),
            int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
